// File: rtl/ovf_status_unit.sv
// ovf_status_unit
//
// Overflow-exception unit at the execute/writeback boundary. Each valid
// instruction is classified from opcode/aluop. If the class can overflow and
// the ALU overflow flag is set, the unit does three things:
//   - it queues a status code for a later write to $rstatus,
//   - it pulses suppress_wb to kill the instruction's normal writeback,
//   - it updates the sticky status, the saturating event count and the loss flag.
// Pending $rstatus writes leave through an in-order FIFO with a ready/valid
// handshake. There is no combinational bypass from the instruction inputs to
// the write port.
//
// Optional feature macro: OVF_MULDIV_EN
//   defined   -> mul (aluop 00110, code 4) and div (aluop 00111, code 5) classify
//   undefined -> those aluops never classify; the port list is the same
//
// Parameters:
//   DEPTH       pending-write FIFO entries (power of two, >= 2)
//   DATAW       width of out_data (> 3)
//   REGW        register-index width
//   RSTATUS_REG register index driven on out_addr
//   CNTW        width of ovf_count
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset; clears all state
//   in_valid       instruction in stage is valid
//   opcode, aluop  instruction fields used for classification
//   ovf            ALU overflow flag for the presented instruction
//   clear          synchronous clear of ovf_count, status_sticky, lost
//   out_valid      FIFO head holds a pending $rstatus write
//   out_ready      writeback port accepts the head this cycle
//   out_addr       constant RSTATUS_REG
//   out_data       head status code, zero-extended (0 when empty)
//   suppress_wb    registered one-cycle kill of last cycle's writeback
//   status_sticky  last status code accepted into the FIFO
//   ovf_count      saturating count of detected overflow events
//   lost           sticky; an event was dropped because the FIFO was full
module ovf_status_unit #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATAW       = 32,
  parameter int unsigned REGW        = 5,
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned CNTW        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       opcode,
  input  logic [4:0]       aluop,
  input  logic             ovf,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REGW-1:0]  out_addr,
  output logic [DATAW-1:0] out_data,
  output logic             suppress_wb,
  output logic [2:0]       status_sticky,
  output logic [CNTW-1:0]  ovf_count,
  output logic             lost
);

  localparam int unsigned PTRW = $clog2(DEPTH);

  typedef logic [2:0] code_t;

  localparam code_t CodeNone = 3'd0;
  localparam code_t CodeAdd  = 3'd1;
  localparam code_t CodeAddi = 3'd2;
  localparam code_t CodeSub  = 3'd3;
`ifdef OVF_MULDIV_EN
  localparam code_t CodeMul  = 3'd4;
  localparam code_t CodeDiv  = 3'd5;
`endif

  localparam logic [4:0] OpAlu  = 5'b00000;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
`ifdef OVF_MULDIV_EN
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;
`endif

  localparam logic [PTRW:0]   PtrOne = {{PTRW{1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Classification
  // ---------------------------------------------------------------------------
  code_t cls_code;
  logic  cls_hit;

  always_comb begin
    cls_code = CodeNone;
    if (opcode == OpAddi) begin
      cls_code = CodeAddi;
    end else if (opcode == OpAlu) begin
      case (aluop)
        AluAdd:  cls_code = CodeAdd;
        AluSub:  cls_code = CodeSub;
`ifdef OVF_MULDIV_EN
        AluMul:  cls_code = CodeMul;
        AluDiv:  cls_code = CodeDiv;
`endif
        default: cls_code = CodeNone;
      endcase
    end
  end

  assign cls_hit = (cls_code != CodeNone);

  // ---------------------------------------------------------------------------
  // Pending-write FIFO
  // ---------------------------------------------------------------------------
  // Pointers carry one extra wrap bit. Equal pointers mean empty. Pointers
  // that differ only in the wrap bit mean full.
  logic [PTRW:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW:0] rd_ptr_q, rd_ptr_d;
  code_t         mem_q [DEPTH];
  code_t         head;

  logic event_hit;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTRW] != rd_ptr_q[PTRW]) &&
                      (wr_ptr_q[PTRW-1:0] == rd_ptr_q[PTRW-1:0]);

  assign event_hit = in_valid && cls_hit && ovf;
  assign pop       = !fifo_empty && out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept the new entry.
  assign push      = event_hit && (!fifo_full || pop);
  assign drop      = event_hit && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset. Stale slots are never visible because
  // out_data is gated by out_valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[PTRW-1:0]] <= cls_code;
  end

  assign head = mem_q[rd_ptr_q[PTRW-1:0]];

  // ---------------------------------------------------------------------------
  // Status, counter, loss flag, writeback suppression
  // ---------------------------------------------------------------------------
  logic            suppress_q;
  code_t           sticky_q, sticky_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            lost_q, lost_d;

  always_comb begin
    count_d  = count_q;
    sticky_d = sticky_q;
    lost_d   = lost_q;
    if (clear) begin
      // Clear wins over the old value, but a same-cycle event still counts.
      count_d  = event_hit ? CntOne : '0;
      sticky_d = push ? cls_code : CodeNone;
      lost_d   = drop;
    end else begin
      if (event_hit && !(&count_q)) count_d = count_q + CntOne;
      if (push) sticky_d = cls_code;
      if (drop) lost_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      suppress_q <= 1'b0;
      sticky_q   <= CodeNone;
      count_q    <= '0;
      lost_q     <= 1'b0;
    end else begin
      suppress_q <= event_hit;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      lost_q     <= lost_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid     = !fifo_empty;
  assign out_addr      = REGW'(RSTATUS_REG);
  assign suppress_wb   = suppress_q;
  assign status_sticky = sticky_q;
  assign ovf_count     = count_q;
  assign lost          = lost_q;

  always_comb begin
    out_data = '0;
    if (!fifo_empty) out_data = {{(DATAW-3){1'b0}}, head};
  end

endmodule

// File: tb/tb_ovf_status_unit.sv
module tb_ovf_status_unit;
  localparam int DEPTH = 4;
  localparam int DATAW = 32;
  localparam int REGW  = 5;
  localparam int RREG  = 30;
  localparam int CNTW  = 4;  // narrow counter so saturation is reachable
  localparam int CMAX  = (1 << CNTW) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [4:0]       opcode = '0;
  logic [4:0]       aluop = '0;
  logic             ovf = 1'b0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [REGW-1:0]  out_addr;
  logic [DATAW-1:0] out_data;
  logic             suppress_wb;
  logic [2:0]       status_sticky;
  logic [CNTW-1:0]  ovf_count;
  logic             lost;

  always #5 clock = ~clock;

  ovf_status_unit #(
    .DEPTH(DEPTH), .DATAW(DATAW), .REGW(REGW), .RSTATUS_REG(RREG), .CNTW(CNTW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode), .aluop(aluop),
    .ovf(ovf), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .suppress_wb(suppress_wb),
    .status_sticky(status_sticky), .ovf_count(ovf_count), .lost(lost)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queue of pending codes plus plain status variables.
  int q[$];
  int m_sticky = 0;
  int m_count = 0;
  int m_lost = 0;
  int m_supp = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int class_code(input logic [4:0] op, input logic [4:0] aop);
    if (op == 5'b00101) return 2;
    if (op != 5'b00000) return 0;
    case (aop)
      5'b00000: return 1;
      5'b00001: return 3;
`ifdef OVF_MULDIV_EN
      5'b00110: return 4;
      5'b00111: return 5;
`endif
      default:  return 0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_sticky = 0;
    m_count = 0;
    m_lost = 0;
    m_supp = 0;
  endtask

  // Applies one clock edge's worth of spec rules using the inputs held across it.
  task automatic model_edge();
    int  code;
    bit  ev, pop, push, drop;
    if (!reset) begin
      model_reset();
      return;
    end
    code = class_code(opcode, aluop);
    ev   = in_valid && (code != 0) && ovf;
    pop  = (q.size() > 0) && out_ready;
    push = ev && ((q.size() < DEPTH) || pop);
    drop = ev && !push;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(code);
    m_supp = ev;
    if (clear) begin
      m_count  = ev ? 1 : 0;
      m_sticky = push ? code : 0;
      m_lost   = drop;
    end else begin
      if (ev && m_count < CMAX) m_count++;
      if (push) m_sticky = code;
      if (drop) m_lost = 1;
    end
  endtask

  // Single compare process: outputs are all register-derived, so mid-cycle is safe.
  always @(negedge clock) begin
    if (chk_en) begin
      check("out_valid", out_valid, q.size() > 0);
      check("out_data", out_data, (q.size() > 0) ? q[0] : 0);
      check("out_addr", out_addr, RREG);
      check("suppress_wb", suppress_wb, m_supp);
      check("status_sticky", status_sticky, m_sticky);
      check("ovf_count", ovf_count, m_count);
      check("lost", lost, m_lost);
    end
  end

  // Drive inputs, let one rising edge happen, return 1ns after it.
  task automatic step(input logic iv, input logic [4:0] op, input logic [4:0] aop,
                      input logic ov, input logic clr, input logic rdy);
    in_valid  = iv;
    opcode    = op;
    aluop     = aop;
    ovf       = ov;
    clear     = clr;
    out_ready = rdy;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic add_ovf(input logic rdy);
    step(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b0, rdy);
  endtask

  initial begin
    logic [4:0] aops [6];
    aops[0] = 5'b00000; aops[1] = 5'b00001; aops[2] = 5'b00010;
    aops[3] = 5'b00110; aops[4] = 5'b00111; aops[5] = 5'b11111;

    repeat (2) @(posedge clock);
    #1;
    // Reset state while reset is held.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", ovf_count, 0);
    check("rst_addr", out_addr, 30);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Single add overflow, drained immediately.
    add_ovf(1'b1);
    check("add_supp", suppress_wb, 1);
    check("add_valid", out_valid, 1);
    check("add_data", out_data, 1);
    check("add_addr", out_addr, 30);
    idle(1'b1);
    check("add_drained", out_valid, 0);
    check("add_count", ovf_count, 1);
    check("add_supp_pulse", suppress_wb, 0);

    // addi then sub back-to-back, drained in order.
    step(1'b1, 5'b00101, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 5'b00001, 1'b1, 1'b0, 1'b0);
    check("order_head0", out_data, 2);
    idle(1'b1);
    check("order_head1", out_data, 3);
    idle(1'b1);
    check("order_empty", out_valid, 0);
    check("order_sticky", status_sticky, 3);

    // Five events into a depth-4 FIFO with no drain: one is lost.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add_ovf(1'b0);
      check("full_supp", suppress_wb, 1);
    end
    check("full_lost", lost, 1);
    check("full_count", ovf_count, 5);
    check("full_valid", out_valid, 1);
    repeat (4) idle(1'b1);
    check("full_drained", out_valid, 0);

    // Same, but a pop coincides with the fifth event: nothing lost.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (4) add_ovf(1'b0);
    add_ovf(1'b1);
    check("nolost_lost", lost, 0);
    check("nolost_count", ovf_count, 5);
    repeat (4) idle(1'b1);
    check("nolost_drained", out_valid, 0);

    // Non-events: no overflow, invalid instruction, unclassified op.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
    check("noev_supp0", suppress_wb, 0);
    step(1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("noev_supp1", suppress_wb, 0);
    step(1'b1, 5'b00000, 5'b00010, 1'b1, 1'b0, 1'b0);
    check("noev_supp2", suppress_wb, 0);
    check("noev_count", ovf_count, 0);
    check("noev_valid", out_valid, 0);

    // mul with overflow.
    step(1'b1, 5'b00000, 5'b00110, 1'b1, 1'b0, 1'b0);
`ifdef OVF_MULDIV_EN
    check("mul_valid", out_valid, 1);
    check("mul_data", out_data, 4);
`else
    check("mul_valid", out_valid, 0);
    check("mul_supp", suppress_wb, 0);
`endif
    idle(1'b1);

    // clear coincident with an event, then reset with three pending entries.
    add_ovf(1'b0);
    step(1'b1, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0);
    check("clr_ev_count", ovf_count, 1);
    add_ovf(1'b0);
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", ovf_count, 0);
    check("mid_rst_lost", lost, 0);
    check("mid_rst_sticky", status_sticky, 0);
    check("mid_rst_data", out_data, 0);
    idle(1'b1);
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [4:0] op;
      r = $urandom_range(0, 9);
      if (r < 6) op = 5'b00000;
      else if (r < 8) op = 5'b00101;
      else op = 5'($urandom);
      step(($urandom_range(0, 9) < 8), op, aops[$urandom_range(0, 5)],
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 1) == 1));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
